// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared peripheral data bus (IDLE -> ACCESS -> ACK).
// Optional grant locking is compiled in with the DBUS_ARB_LOCK_EN macro.
`timescale 1ns/1ps

module data_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [1:0]            m0_mode,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_lock,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [1:0]            m1_mode,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] data_bus_addr,
  output logic [1:0]            data_bus_mode,
  inout  wire  [DATA_WIDTH-1:0] data_bus_data
);

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_ACK = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic                    elig0_c, elig1_c, pick_c, grant_c;
  logic                    last_grant, winner, is_read, drive;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [ADDR_WIDTH-1:0]   sel_addr_c, addr_nxt;
  logic [1:0]              sel_mode_c, mode_nxt;
  logic [DATA_WIDTH-1:0]   sel_wdata_c;
  logic                    drive_nxt, ack0_nxt, ack1_nxt;

  assign data_bus_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef DBUS_ARB_LOCK_EN
  localparam int unsigned     LCW      = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0]  LOCK_MAX = LCW'(MAX_LOCK);

  logic           lock_valid, lock_owner;
  logic [LCW-1:0] lock_cnt;
  logic           owner_lock_c, lock_force_c, lock_rel_c, lock_hold_c;

  // A held lock makes the owner the only eligible master; an expired lock favours the other one.
  always_comb begin
    owner_lock_c = lock_owner ? m1_lock : m0_lock;
    lock_force_c = lock_valid && (lock_cnt >= LOCK_MAX);
    lock_rel_c   = lock_valid && (!owner_lock_c || lock_force_c);
    lock_hold_c  = lock_valid && !lock_rel_c;
    elig0_c      = m0_req && !(lock_hold_c && lock_owner);
    elig1_c      = m1_req && !(lock_hold_c && !lock_owner);
    if (elig0_c && elig1_c) pick_c = lock_force_c ? !lock_owner : !last_grant;
    else                    pick_c = elig1_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (grant_c && (pick_c ? m1_lock : m0_lock)) begin
        lock_valid <= 1'b1;
        lock_owner <= pick_c;
        lock_cnt   <= (lock_valid && !lock_rel_c && (lock_owner == pick_c)) ?
                      lock_cnt + LCW'(1) : LCW'(1);
      end else if (grant_c || lock_rel_c) begin
        lock_valid <= 1'b0;
        lock_cnt   <= '0;
      end
    end
  end
`else
  logic unused_lock;

  assign unused_lock = m0_lock | m1_lock | (MAX_LOCK == 0);
  assign elig0_c     = m0_req;
  assign elig1_c     = m1_req;
  assign pick_c      = elig1_c && (!elig0_c || !last_grant);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (elig0_c || elig1_c) begin
          grant_c   = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nxt = ST_ACK;
      ST_ACK:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered bus and ack outputs.
  always_comb begin
    sel_addr_c  = pick_c ? m1_addr  : m0_addr;
    sel_mode_c  = pick_c ? m1_mode  : m0_mode;
    sel_wdata_c = pick_c ? m1_wdata : m0_wdata;
    addr_nxt    = '0;
    mode_nxt    = MODE_IDLE;
    drive_nxt   = 1'b0;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_c) begin
          addr_nxt  = sel_addr_c;
          if (sel_mode_c == MODE_READ || sel_mode_c == MODE_WRITE) mode_nxt = sel_mode_c;
          drive_nxt = (sel_mode_c == MODE_WRITE);
        end
      end
      ST_ACCESS: begin
        ack0_nxt = !winner;
        ack1_nxt = winner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_bus_addr <= '0;
      data_bus_mode <= MODE_IDLE;
      drive         <= 1'b0;
      m0_ack        <= 1'b0;
      m1_ack        <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
      last_grant    <= 1'b1;
      winner        <= 1'b0;
      is_read       <= 1'b0;
      wdata_q       <= '0;
    end else begin
      data_bus_addr <= addr_nxt;
      data_bus_mode <= mode_nxt;
      drive         <= drive_nxt;
      m0_ack        <= ack0_nxt;
      m1_ack        <= ack1_nxt;
      if (grant_c) begin
        winner     <= pick_c;
        last_grant <= pick_c;
        is_read    <= (sel_mode_c == MODE_READ);
        wdata_q    <= sel_wdata_c;
      end
      // Slave read data is sampled at the end of the ACCESS cycle.
      if (state == ST_ACCESS && is_read) begin
        if (winner) m1_rdata <= data_bus_data;
        else        m0_rdata <= data_bus_data;
      end
    end
  end

endmodule
